// File: rtl/ring_load_conditioner.sv
// Input conditioning ahead of the ring counter: synchronizes and debounces the
// ALOAD pushbutton into a one-cycle load pulse plus a clean level, and derives a
// single-cycle advance tick from the system clock so the ring runs on one clock.
module ring_load_conditioner #(
    parameter int unsigned DB_COUNT = 1000000,
    parameter int unsigned TICK_DIV = 12500000
) (
    input  logic clk,
    input  logic clr,
    input  logic btn_in,
    input  logic en,
    output logic aload,
    output logic btn_level,
    output logic tick
);

    localparam int unsigned DbW = $clog2(DB_COUNT + 1);
    localparam int unsigned PcW = $clog2(TICK_DIV);
    localparam logic [DbW-1:0] DbLast = DbW'(DB_COUNT);
    localparam logic [PcW-1:0] PcLast = PcW'(TICK_DIV - 1);

    typedef enum logic [1:0] {
        StIdle,
        StPressWait,
        StHeld,
        StReleaseWait
    } db_state_e;

    // Synchronizer
    logic s1_q, s1_d;
    logic s2_q, s2_d;

    // Debounce
    db_state_e state_q, state_d;
    logic [DbW-1:0] cnt_q, cnt_d;
    logic [DbW-1:0] cnt_inc;
    logic press_accept;
    logic level_q, level_d;
    logic aload_q, aload_d;

    // Prescaler
    logic [PcW-1:0] pc_q, pc_d;
    logic tick_q, tick_d;

    // Two-flop synchronizer next state; the FSM only ever looks at s2.
    always_comb begin
        s1_d = btn_in;
        s2_d = s1_q;
    end

    // Debounce next state. The counter is 0 in IDLE/HELD, so the same
    // increment-and-compare serves both the first sample and the following ones,
    // which also makes DB_COUNT=1 jump straight between IDLE and HELD.
    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        press_accept = 1'b0;
        cnt_inc      = cnt_q + DbW'(1);
        unique case (state_q)
            StIdle, StPressWait: begin
                if (s2_q) begin
                    if (cnt_inc == DbLast) begin
                        state_d      = StHeld;
                        cnt_d        = '0;
                        press_accept = 1'b1;
                    end else begin
                        state_d = StPressWait;
                        cnt_d   = cnt_inc;
                    end
                end else begin
                    state_d = StIdle;
                    cnt_d   = '0;
                end
            end
            StHeld, StReleaseWait: begin
                if (!s2_q) begin
                    if (cnt_inc == DbLast) begin
                        state_d = StIdle;
                        cnt_d   = '0;
                    end else begin
                        state_d = StReleaseWait;
                        cnt_d   = cnt_inc;
                    end
                end else begin
                    state_d = StHeld;
                    cnt_d   = '0;
                end
            end
            default: begin
                state_d = StIdle;
                cnt_d   = '0;
            end
        endcase
    end

    // Registered status outputs follow the state being entered.
    always_comb begin
        level_d = (state_d == StHeld) || (state_d == StReleaseWait);
        aload_d = press_accept;
    end

    // Prescaler: an accepted press realigns the tick phase and suppresses a
    // coincident wrap, so load always wins over advance.
    always_comb begin
        pc_d   = pc_q;
        tick_d = 1'b0;
        if (press_accept) begin
            pc_d = '0;
        end else if (!en) begin
            pc_d = pc_q;
        end else if (pc_q == PcLast) begin
            pc_d   = '0;
            tick_d = 1'b1;
        end else begin
            pc_d = pc_q + PcW'(1);
        end
    end

    // Synchronizer flops.
    always_ff @(posedge clk or negedge clr) begin
        if (!clr) begin
            s1_q <= 1'b0;
            s2_q <= 1'b0;
        end else begin
            s1_q <= s1_d;
            s2_q <= s2_d;
        end
    end

    // Debounce state, counter and registered button outputs.
    always_ff @(posedge clk or negedge clr) begin
        if (!clr) begin
            state_q <= StIdle;
            cnt_q   <= '0;
            level_q <= 1'b0;
            aload_q <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            level_q <= level_d;
            aload_q <= aload_d;
        end
    end

    // Prescaler state and tick strobe.
    always_ff @(posedge clk or negedge clr) begin
        if (!clr) begin
            pc_q   <= '0;
            tick_q <= 1'b0;
        end else begin
            pc_q   <= pc_d;
            tick_q <= tick_d;
        end
    end

    assign aload     = aload_q;
    assign btn_level = level_q;
    assign tick      = tick_q;

endmodule

// File: doc/ring_load_conditioner.md
# ring_load_conditioner

Input-conditioning stage directly upstream of the ring counter. It turns the raw, bouncy ALOAD pushbutton into a clean one-cycle load pulse, and it generates a single-cycle advance tick from the board clock. The ring counter then runs on one clock with enables instead of on a divided clock. The block also exposes a debounced button level for status LEDs.

## Interface
- `DB_COUNT`, default 1000000: consecutive stable samples required to accept a button change (20 ms at 50 MHz); legal range ≥1.
- `TICK_DIV`, default 12500000: clock cycles per advance tick (4 Hz at 50 MHz); legal range ≥2.
- `clk`, input, 1: single system clock; all state is on its rising edge.
- `clr`, input, 1: reset, asynchronous, active-low; asserting it (0) immediately clears all state.
- `btn_in`, input, 1: raw asynchronous ALOAD pushbutton; 1 = pressed.
- `en`, input, 1: tick enable; 0 freezes the prescaler.
- `aload`, output, 1: one-cycle load pulse to the ring counter, generated on an accepted press only.
- `btn_level`, output, 1: debounced button level.
- `tick`, output, 1: one-cycle advance strobe to the ring counter.

## Operation
- Synchronizer: two flops, `s1` then `s2`, on `btn_in`; both reset to 0. The FSM sees only `s2`.
- Debounce FSM:
  - IDLE (level 0): `s2`=1 → PRESS_WAIT with counter=1.
  - PRESS_WAIT: `s2`=1 → counter+1; counter reaching DB_COUNT → HELD. `s2`=0 → IDLE with counter=0.
  - HELD (level 1): `s2`=0 → RELEASE_WAIT with counter=1.
  - RELEASE_WAIT: `s2`=0 → counter+1; counter reaching DB_COUNT → IDLE. `s2`=1 → HELD with counter=0.
  - DB_COUNT=1 goes straight from IDLE to HELD and from HELD to IDLE.
- Counter width is clog2(DB_COUNT+1). It never exceeds DB_COUNT and is 0 in IDLE and HELD.
- `btn_level` is registered: 1 in HELD and RELEASE_WAIT, 0 in IDLE and PRESS_WAIT.
- `aload` is registered and is 1 only in the cycle right after the PRESS_WAIT→HELD edge. Release never pulses. Holding the button gives exactly one pulse.
- Prescaler counter `pc` has width clog2(TICK_DIV) and runs 0..TICK_DIV-1.
- Each edge, highest priority first:
  - If the edge enters HELD from PRESS_WAIT: `pc`←0 and `tick`←0, so ring timing realigns to the load.
  - Else if `en`=0: `pc` holds and `tick`←0.
  - Else if `pc`=TICK_DIV-1: `pc`←0 and `tick`←1.
  - Else: `pc`+1 and `tick`←0.
- A simultaneous accepted press and prescaler wrap gives `aload`=1 and `tick`=0 (load wins).
- Reset values: `aload`=0, `tick`=0, `btn_level`=0, FSM=IDLE, all counters 0.
- Reset mid-debounce or mid-count discards all progress. After release, the button must be stable for DB_COUNT samples again.

## Timing
- Press latency: `btn_in` is first sampled high at edge 1 and stays stable. `s2`=1 after edge 2. The FSM enters HELD at edge DB_COUNT+2. `aload` and `btn_level` are high after that edge, and `aload` is high for exactly one cycle.
- Release latency is symmetric: `btn_level` falls after edge DB_COUNT+2, with no pulse.
- Bounce shorter than DB_COUNT samples causes no output change.
- Tick spacing: with `en`=1 and no loads, `tick` is high for one cycle every TICK_DIV cycles. The first tick comes after the TICK_DIV-th edge following reset or a load.
- `en` deassert/reassert shifts the tick phase by the number of disabled cycles; no tick is lost or duplicated.
- No combinational path from any input to any output.

## Test plan
Bench parameters: DB_COUNT=4, TICK_DIV=5.
- Reset: hold `clr`=0 with `btn_in`=1, `en`=1 → all outputs 0 throughout. Release `clr` → `aload` and `btn_level` rise after edge 6.
- Clean press: `btn_in` 0→1 held 20 cycles → exactly one `aload` pulse after edge 6; `btn_level`=1 until release. Release → `btn_level` 0 after 6 edges, no `aload`.
- Bounce: `btn_in` toggles 1,1,1,0,1,1,0 then stays 0 → `btn_level` stays 0 and `aload` never fires.
- Tick cadence: `en`=1, no button, 30 cycles → `tick` after edges 5, 10, 15, 20, 25, 30, each one cycle wide. Drop `en` for 3 cycles starting at edge 12 → next ticks after edges 18 and 23.
- Load realign: time an accepted press to land on the edge where `pc`=4 → `aload`=1, `tick`=0 on that edge; next tick 5 edges later.
- Async reset mid-PRESS_WAIT: drop `clr` for half a cycle at debounce count 3, keep the button pressed → counting restarts; `aload` arrives 6 edges after `clr` returns high.
